// File: rtl/bus_read_sequencer_pkg.sv
// Shared types and constants for the datapath bus read sequencer.
// Holds the FSM state encoding, the settle counter width and the default bus width.
package bus_read_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Settle counter width; supports settle windows of 1..15 cycles.
  localparam int unsigned SETTLE_CNT_W = 4;

  localparam int unsigned BUS_W_DEFAULT = 32;

endpackage

// File: rtl/bus_read_sequencer_oe_dec.sv
// Combinational source-index to one-hot output-enable decoder.
// An index at or beyond NUM_SRC yields all-zero enables and raises oor_c.
module oe_onehot_dec
  import bus_read_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned SRC_W   = 3
) (
  input  logic [SRC_W-1:0]   idx_i,
  output logic [NUM_SRC-1:0] onehot_c,
  output logic               oor_c
);

  always_comb begin
    onehot_c = '0;
    oor_c    = (32'(idx_i) >= NUM_SRC);
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (idx_i == SRC_W'(i)) begin
        onehot_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_read_sequencer.sv
// Reader/arbiter for the shared tri-state datapath bus: grants one driver's output
// enable for a settle window, samples the bus, and returns the word via valid/ready.
module bus_read_sequencer
  import bus_read_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 8,
  parameter int unsigned SRC_W      = 3,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned DATA_W     = BUS_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SRC_W-1:0]   req_src,
  output logic [NUM_SRC-1:0] src_oe,
  input  logic [DATA_W-1:0]  bus_data,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data,
  output logic               resp_err
);

  localparam logic [SETTLE_CNT_W-1:0] LAST_CNT = SETTLE_CNT_W'(SETTLE_CYC - 1);

  state_e                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0]      oe_q, oe_d;
  logic                    err_q, err_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]       resp_data_q, resp_data_d;
  logic                    resp_err_q, resp_err_d;

  logic [NUM_SRC-1:0]      dec_onehot;
  logic                    dec_oor;

  oe_onehot_dec #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_oe_dec (
    .idx_i    (req_src),
    .onehot_c (dec_onehot),
    .oor_c    (dec_oor)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    oe_d         = oe_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        oe_d = '0;
        if (req_valid) begin
          state_d = ST_DRIVE;
          oe_d    = dec_onehot;
          err_d   = dec_oor;
          cnt_d   = '0;
        end
      end

      ST_DRIVE: begin
        cnt_d = cnt_q + SETTLE_CNT_W'(1);
        // Last settle cycle: sample the bus and release the driver together.
        if (cnt_q == LAST_CNT) begin
          resp_data_d  = err_q ? '0 : bus_data;
          resp_err_d   = err_q;
          resp_valid_d = 1'b1;
          oe_d         = '0;
          state_d      = ST_RESP;
        end
      end

      ST_RESP: begin
        oe_d = '0;
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        oe_d         = '0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      oe_q         <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      oe_q         <= oe_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign src_oe     = oe_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Bench for bus_read_sequencer: three instances (8 src/settle 1, 8 src/settle 3,
// 6 src/settle 1), each with its own register-file bus model.
module tb_bus_read_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [2:0]  req_src    [3];
  logic [7:0]  src_oe     [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_data  [3];
  logic        resp_err   [3];

  logic [31:0] reg_val [3][8];
  logic [7:0]  prev_oe [3];

  int total = 0;
  int bad   = 0;

  function automatic int unsigned ns_of(int g);
    return (g == 2) ? 6 : 8;
  endfunction

  function automatic int unsigned st_of(int g);
    return (g == 1) ? 3 : 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NS = (g == 2) ? 6 : 8;
    localparam int unsigned ST = (g == 1) ? 3 : 1;
    logic [NS-1:0] oe;
    logic [31:0]   bd;

    bus_read_sequencer #(
      .NUM_SRC    (NS),
      .SRC_W      (3),
      .SETTLE_CYC (ST),
      .DATA_W     (32)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_src    (req_src[g]),
      .src_oe     (oe),
      .bus_data   (bd),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .resp_err   (resp_err[g])
    );

    assign src_oe[g] = 8'(oe);

    // Register file on the bus: the enabled driver's value, else a recognisable idle pattern.
    always_comb begin
      bd = 32'hBAD0_BAD0;
      for (int i = 0; i < int'(NS); i++) begin
        if (oe[i]) bd = reg_val[g][i];
      end
    end

    a_onehot: assert property (@(posedge clk) $onehot0(oe))
      else $error("src_oe multi-hot on instance %0d", g);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and audit every instance's enables.
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("onehot0[%0d]", g), 32'($onehot0(src_oe[g])), 32'd1);
      if (src_oe[g] != 8'd0 && prev_oe[g] != 8'd0)
        chk($sformatf("break_before_make[%0d]", g), 32'(src_oe[g]), 32'(prev_oe[g]));
      prev_oe[g] = src_oe[g];
    end
  endtask

  task automatic do_txn(input int g, input logic [2:0] src, input int dly,
                        input logic [7:0] eoe, input logic [31:0] edata, input logic eerr);
    int n = 0;
    while (!req_ready[g] && n < 40) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(req_ready[g]), 32'd1);
    req_valid[g]  = 1'b1;
    req_src[g]    = src;
    resp_ready[g] = 1'b0;
    tick();
    req_valid[g] = 1'b0;
    req_src[g]   = 3'($urandom);
    for (int k = 0; k < int'(st_of(g)); k++) begin
      chk("drive_oe", 32'(src_oe[g]), 32'(eoe));
      chk("drive_rv", 32'(resp_valid[g]), 32'd0);
      chk("drive_rdy", 32'(req_ready[g]), 32'd0);
      tick();
    end
    chk("resp_rv", 32'(resp_valid[g]), 32'd1);
    chk("resp_data", resp_data[g], edata);
    chk("resp_err", 32'(resp_err[g]), 32'(eerr));
    chk("resp_oe", 32'(src_oe[g]), 32'd0);
    chk("resp_rdy", 32'(req_ready[g]), 32'd0);
    for (int d = 0; d < dly; d++) begin
      tick();
      chk("hold_rv", 32'(resp_valid[g]), 32'd1);
      chk("hold_data", resp_data[g], edata);
      chk("hold_err", 32'(resp_err[g]), 32'(eerr));
      chk("hold_rdy", 32'(req_ready[g]), 32'd0);
    end
    resp_ready[g] = 1'b1;
    tick();
    resp_ready[g] = 1'b0;
    chk("done_rv", 32'(resp_valid[g]), 32'd0);
    chk("done_err", 32'(resp_err[g]), 32'd0);
    chk("done_rdy", 32'(req_ready[g]), 32'd1);
    chk("done_data_kept", resp_data[g], edata);
  endtask

  typedef struct {
    int          g;
    logic [2:0]  src;
    logic [31:0] val;
    int          dly;
    logic [7:0]  eoe;
    logic [31:0] edata;
    logic        eerr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 3'd3, 32'hDEAD_BEEF, 0, 8'h08, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1, 3'd5, 32'hCAFE_F00D, 4, 8'h20, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{2, 3'd7, 32'h1234_5678, 0, 8'h00, 32'h0000_0000, 1'b1};
    vecs[3] = '{2, 3'd5, 32'hA5A5_A5A5, 1, 8'h20, 32'hA5A5_A5A5, 1'b0};
    vecs[4] = '{2, 3'd6, 32'h5555_AAAA, 2, 8'h00, 32'h0000_0000, 1'b1};
    vecs[5] = '{0, 3'd0, 32'h0000_0001, 0, 8'h01, 32'h0000_0001, 1'b0};
    vecs[6] = '{1, 3'd7, 32'h8000_0000, 0, 8'h80, 32'h8000_0000, 1'b0};

    for (int g = 0; g < 3; g++) begin
      prev_oe[g] = 8'd0;
      for (int s = 0; s < 8; s++) reg_val[g][s] = $urandom;
    end

    // Reset with inputs toggling.
    for (int c = 0; c < 3; c++) begin
      for (int g = 0; g < 3; g++) begin
        rst[g]        = 1'b1;
        req_valid[g]  = 1'($urandom);
        req_src[g]    = 3'($urandom);
        resp_ready[g] = 1'($urandom);
      end
      tick();
      for (int g = 0; g < 3; g++) begin
        chk("rst_oe", 32'(src_oe[g]), 32'd0);
        chk("rst_rv", 32'(resp_valid[g]), 32'd0);
        chk("rst_data", resp_data[g], 32'd0);
        chk("rst_err", 32'(resp_err[g]), 32'd0);
      end
    end
    for (int g = 0; g < 3; g++) begin
      rst[g]        = 1'b0;
      req_valid[g]  = 1'b0;
      resp_ready[g] = 1'b0;
    end
    tick();
    for (int g = 0; g < 3; g++) chk("post_rst_rdy", 32'(req_ready[g]), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      reg_val[vecs[i].g][vecs[i].src] = vecs[i].val;
      do_txn(vecs[i].g, vecs[i].src, vecs[i].dly, vecs[i].eoe, vecs[i].edata, vecs[i].eerr);
    end

    // Back-to-back src=0 then src=7, resp_ready and req_valid held high.
    begin
      logic [31:0] got [$];
      int t_first = -1;
      int t_second = -1;
      int zeros = 0;
      reg_val[0][0] = $urandom;
      reg_val[0][7] = $urandom;
      resp_ready[0] = 1'b1;
      req_valid[0]  = 1'b1;
      req_src[0]    = 3'd0;
      for (int t = 0; t < 20 && got.size() < 2; t++) begin
        tick();
        if (src_oe[0] == 8'h01 && t_first < 0) begin
          t_first = t;
          req_src[0] = 3'd7;
        end
        if (t_first >= 0 && t_second < 0 && src_oe[0] == 8'd0) zeros++;
        if (src_oe[0] == 8'h80 && t_second < 0) t_second = t;
        if (resp_valid[0]) got.push_back(resp_data[0]);
      end
      req_valid[0] = 1'b0;
      chk("b2b_count", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
        chk("b2b_data0", got[0], reg_val[0][0]);
        chk("b2b_data1", got[1], reg_val[0][7]);
      end
      chk("b2b_gap_nonzero", 32'(zeros >= 1), 32'd1);
      chk("b2b_spacing", 32'(t_second - t_first), 32'd3);
      repeat (3) tick();
      resp_ready[0] = 1'b0;
      chk("b2b_idle", 32'(req_ready[0]), 32'd1);
    end

    // Reset asserted mid-DRIVE on the 3-cycle instance.
    begin
      int n = 0;
      while (!req_ready[1] && n < 20) begin
        tick();
        n++;
      end
      req_valid[1] = 1'b1;
      req_src[1]   = 3'd2;
      tick();
      req_valid[1] = 1'b0;
      chk("mid_rst_drive_oe", 32'(src_oe[1]), 32'h04);
      rst[1] = 1'b1;
      tick();
      rst[1] = 1'b0;
      chk("mid_rst_oe", 32'(src_oe[1]), 32'd0);
      chk("mid_rst_idle", 32'(req_ready[1]), 32'd1);
      resp_ready[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin
        tick();
        chk("mid_rst_no_resp", 32'(resp_valid[1]), 32'd0);
      end
      resp_ready[1] = 1'b0;
    end

    // Randomized transactions against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      int          g   = int'($urandom_range(0, 2));
      logic [2:0]  src = 3'($urandom_range(0, 7));
      int          dly = int'($urandom_range(0, 3));
      logic        oor = (32'(src) >= ns_of(g));
      logic [7:0]  eoe;
      logic [31:0] edata;
      reg_val[g][src] = $urandom;
      eoe   = oor ? 8'd0 : 8'(1 << src);
      edata = oor ? 32'd0 : reg_val[g][src];
      do_txn(g, src, dly, eoe, edata, oor);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_read_sequencer.md
Name: bus_read_sequencer

Overview:
- Reader and arbiter for the shared internal 32-bit tri-state datapath bus in the multicycle core.
- Every register on the bus has a write enable and a tri-state output enable. This block owns all the output enables: exactly one source drives the bus at a time.
- It accepts a read request naming a source, drives that source's output enable for a settle window, and captures the bus value.
- It returns the captured word over a valid/ready response handshake. The control FSM uses it for operand and datapath register reads.

Parameters:
- NUM_SRC, 8, number of bus drivers; one output-enable line each.
- SRC_W, 3, width of the source index; must satisfy 2**SRC_W >= NUM_SRC.
- SETTLE_CYC, 1, cycles the output enable is held before sampling; legal range 1..15.
- DATA_W, 32, bus and response data width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  read request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_src  in  SRC_W  index of the source to read.
- src_oe  out  NUM_SRC  one-hot or all-zero output-enable lines to the bus drivers.
- bus_data  in  DATA_W  shared tri-state bus.
- resp_valid  out  1  captured data available.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_W  captured bus word.
- resp_err  out  1  request named an out-of-range source.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset: state=IDLE; src_oe=0; resp_valid=0; resp_data=0; resp_err=0; settle count=0.
- All outputs are registered except req_ready, which is decoded from state.
- FSM states are IDLE, DRIVE and RESP.
- IDLE:
  - req_ready=1 and src_oe=0.
  - When req_valid is high at an edge, latch req_src and move to DRIVE.
  - At the same edge, load src_oe with onehot(req_src) and clear the settle count.
  - If req_src >= NUM_SRC: src_oe stays 0 and an error flag is latched.
- DRIVE:
  - Lasts exactly SETTLE_CYC cycles.
  - req_valid is ignored.
  - src_oe holds its value throughout.
  - The settle count increments each edge.
  - At the edge where count == SETTLE_CYC-1:
    - resp_data <= bus_data, or 0 if the error flag is set;
    - resp_err <= error flag;
    - resp_valid <= 1;
    - src_oe <= 0;
    - state goes to RESP.
- RESP:
  - resp_valid, resp_data and resp_err hold stable until an edge where resp_ready is high.
  - At that edge: resp_valid <= 0, resp_err <= 0, state goes to IDLE.
  - resp_data keeps its last value.
- Latency: accept at edge E0; src_oe is high for cycles E0..E0+SETTLE_CYC; resp_valid rises at edge E0+SETTLE_CYC.
- Throughput: at most one request per SETTLE_CYC+2 cycles when resp_ready is held high.
- Break-before-make: there is always at least one cycle with src_oe==0 between two grants, because RESP and IDLE both drive 0.
- src_oe is never multi-hot, in any state and at any time.
- A request arriving while not in IDLE waits (req_ready=0). The requester must hold req_valid and req_src stable until accepted.
- resp_ready asserted while resp_valid=0 has no effect.
- Reset mid-operation:
  - Clears state at the next edge.
  - src_oe drops to 0 in the same edge.
  - Any pending response is discarded.
- The block is never itself a bus driver. bus_data is only sampled, never driven.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, DRIVE=2'd1, RESP=2'd2);
  - SETTLE counter width constant (4 bits);
  - the bus width default of 32.
- One sub-module, oe_onehot_dec: combinational SRC_W-to-NUM_SRC one-hot decoder with an out-of-range flag. It is instantiated once; its output feeds the src_oe register.
- The FSM, settle counter and response registers live in the top module.

Test Plan:
- Reset with all inputs toggling:
  - src_oe=0, resp_valid=0, resp_data=0, resp_err=0 after the first edge with rst=1.
  - req_ready=1 on the edge after rst falls.
- SETTLE_CYC=1, request src=3, bus model drives 32'hDEADBEEF when src_oe[3]:
  - src_oe=8'b0000_1000 for exactly 1 cycle;
  - resp_valid rises 1 cycle after accept with resp_data=32'hDEADBEEF and resp_err=0.
- SETTLE_CYC=3, request src=5, resp_ready held low for 4 cycles:
  - src_oe high for 3 cycles;
  - response held stable for all 4 cycles;
  - req_ready=0 until the edge after resp_ready rises.
- Back-to-back requests src=0 then src=7 with resp_ready=1 and req_valid held high:
  - assertion checks src_oe is never multi-hot;
  - at least one all-zero src_oe cycle between the grants;
  - resp_data values match the bus model, in order.
- NUM_SRC=6, request src=7:
  - src_oe stays 0;
  - resp_err=1 and resp_data=0 after SETTLE_CYC cycles.
- Assert rst during DRIVE (src=2):
  - src_oe=0 and state IDLE on the next edge;
  - no resp_valid pulse follows.
